// File: rtl/memory_arbiter_pkg.sv
// Shared memory-interface definitions: arbiter state/owner enums and the memu command payload.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT_VALID
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } memu_cmd_t;

  localparam logic [31:0] FETCH_WMASK = 32'hffff_ffff;

  // Fetches are always full-word reads.
  function automatic memu_cmd_t fetch_cmd(input logic [31:0] addr);
    memu_cmd_t c;
    c.write = 1'b0;
    c.addr  = addr;
    c.wdata = 32'h0;
    c.wmask = FETCH_WMASK;
    return c;
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// Fetch/data arbiter onto one memory unit: 0-cycle command forward in IDLE, response pulses with memu_valid.
// Backpressure: memu_cmd_ready=0 parks the grant in HOLD; one read outstanding, starvation-bounded data priority.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_start,
  input  logic [31:0] i_addr,
  input  logic        i_kill,
  output logic        i_cmd_ready,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic        d_cmd_ready,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        memu_cmd_start,
  output logic        memu_cmd_write,
  output logic [31:0] memu_addr,
  output logic [31:0] memu_wdata,
  output logic [31:0] memu_wmask,
  input  logic        memu_cmd_ready,
  input  logic        memu_valid,
  input  logic [31:0] memu_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_t           state_q, state_d;
  owner_t           grant_q, grant;
  owner_t           owner_q;
  logic [CNT_W-1:0] starve_q;
  logic             drop_q;
  logic             i_req;
  logic             start;
  logic             cmd_start;
  logic             accept;
  logic             rsp;
  memu_cmd_t        cmd;

  assign i_req = i_cmd_start & ~i_kill;

  always_comb begin
    grant = grant_q;
    start = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_cmd_start && (starve_q < CNT_MAX)) grant = OWN_D;
        else if (i_req)                          grant = OWN_I;
        else                                     grant = OWN_D;
        start = (grant == OWN_I) ? i_req : d_cmd_start;
      end
      HOLD:    start = (grant_q == OWN_I) ? i_req : d_cmd_start;
      default: start = 1'b0;
    endcase
  end

  always_comb begin
    cmd = fetch_cmd(i_addr);
    if (grant == OWN_D) begin
      cmd.write = d_cmd_write;
      cmd.addr  = d_addr;
      cmd.wdata = d_wdata;
      cmd.wmask = d_wmask;
    end
  end

  assign cmd_start = start & rst_n;
  assign accept    = cmd_start & memu_cmd_ready;

  assign memu_cmd_start = cmd_start;
  assign memu_cmd_write = cmd.write;
  assign memu_addr      = cmd.addr;
  assign memu_wdata     = cmd.wdata;
  assign memu_wmask     = cmd.wmask;

  assign i_cmd_ready = accept & (grant == OWN_I);
  assign d_cmd_ready = accept & (grant == OWN_D);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept)                             state_d = cmd.write ? IDLE : WAIT_VALID;
        else if (cmd_start)                     state_d = HOLD;
        else                                    state_d = IDLE;
      end
      WAIT_VALID: if (memu_valid)               state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  // A kill arriving in the same cycle as the response still suppresses it.
  assign rsp     = rst_n & (state_q == WAIT_VALID) & memu_valid;
  assign i_valid = rsp & (owner_q == OWN_I) & ~drop_q & ~i_kill;
  assign d_valid = rsp & (owner_q == OWN_D);
  assign i_rdata = rst_n ? memu_rdata : 32'h0;
  assign d_rdata = rst_n ? memu_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= OWN_D;
      owner_q  <= OWN_D;
      starve_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_start && !memu_cmd_ready) grant_q <= grant;
      if (accept) owner_q <= grant;

      if (state_d == IDLE)
        drop_q <= 1'b0;
      else if (i_kill && ((accept && grant == OWN_I) ||
                          (state_q == WAIT_VALID && owner_q == OWN_I)))
        drop_q <= 1'b1;

      if (accept && grant == OWN_I)
        starve_q <= '0;
      else if (accept && grant == OWN_D && i_cmd_start) begin
        if (starve_q != CNT_MAX) starve_q <= starve_q + CNT_W'(1);
      end else if (state_q == IDLE && !i_cmd_start)
        starve_q <= '0;
    end
  end

endmodule
